mac_pipe_param: RTL and testbench
=================================

Name: mac_pipe_param

Overview:
Parametrised pipelined signed multiply-accumulate unit. It computes a dot product over a vector of (a,b) pairs and delimits each vector with last_in. It emits one result per vector with a single-cycle valid_out pulse and a per-vector overflow flag. Full throughput is one pair per cycle. It is the generalised successor of the fixed 14/28-bit single-pipeline-stage MAC and sits between the operand feeder and the result collector.

Parameters:
IN_W, 14, signed operand width (a, b).
ACC_W, 28, accumulator/result width; must be >= 2*IN_W; product sign-extended to ACC_W.
MULT_STAGES, 1, pipeline registers between multiplier and accumulator; legal range 0..3.

Ports:
clk  input  1  clock, all state updates on posedge.
reset  input  1  synchronous, active-high; clears all state.
a  input  IN_W  signed operand A.
b  input  IN_W  signed operand B.
valid_in  input  1  a/b/last_in valid this cycle.
last_in  input  1  final pair of the current vector; ignored when valid_in=0.
f  output  ACC_W  signed dot-product result; holds until the next result.
valid_out  output  1  one-cycle pulse when f carries a new result.
ovf_out  output  1  saturation (or wrap) occurred in the vector now on f; updates with f.

Behaviour:
- Reset is synchronous and active-high, sampled on the clk posedge. All registers are cleared: f=0, valid_out=0, ovf_out=0, accumulator=0, sticky overflow=0, all pipeline valid/last bits=0. valid_in is ignored while reset=1.
- Stage 0: on a posedge with valid_in=1, register a, b and last_in, and set v0=1. Otherwise v0=0 and data registers hold.
- The multiplier is combinational on the stage-0 registers. The product (2*IN_W bits) is sign-extended to ACC_W.
- MULT_STAGES registers carry the product together with its valid and last bits. They load only when the upstream valid bit is 1; the valid bits themselves always shift.
- Accumulate stage: sum = acc + prod, then saturated (see Optional Feature). Overflow condition: both operands have the same sign and the raw sum has the opposite sign.
  - Valid and not last: acc <= sum; sticky_ovf |= overflow.
  - Valid and last: f <= sum; ovf_out <= sticky_ovf | overflow; valid_out <= 1; acc <= 0; sticky_ovf <= 0. The next vector starts from zero.
  - Not valid (bubble): acc and sticky_ovf hold; valid_out <= 0.
- Latency: a last pair sampled at edge E gives f and valid_out visible after edge E+MULT_STAGES+1.
  - MULT_STAGES=1: 2 edges. MULT_STAGES=0: 1 edge.
- valid_out is high for exactly one cycle per last pair. Back-to-back single-pair vectors give consecutive valid_out pulses.
- Bubbles anywhere in a vector do not change the result.
- A reset asserted mid-vector discards all in-flight pairs and the partial sum. No valid_out is produced for the aborted vector.
- There is no backpressure. Downstream must accept every valid_out pulse.

Optional Feature:
Macro MAC_PIPE_SAT_EN.
- Defined: on overflow, sum clamps to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)), matching the sign of the operands.
- Undefined: sum wraps in two's complement.
- In both cases overflow is detected and reported on ovf_out identically.

Decomposition:
- Package mac_pipe_pkg holds:
  - default width constants IN_W_DEF=14, ACC_W_DEF=28;
  - function sat_max(w) / sat_min(w);
  - typedef of the pipeline entry struct {prod, valid, last}, parametrised by width through localparams in the module.
- One sub-module, mac_sat_add. It is a combinational ACC_W saturating/wrapping adder with an ovf output, and it contains the MAC_PIPE_SAT_EN conditional.
- The pipeline is a generate loop over MULT_STAGES inside mac_pipe_param.

Test Plan:
1. Single-pair vector, defaults: a=3, b=4, last=1. Expect valid_out=1 for one cycle 2 edges later, f=12, ovf_out=0.
2. Vector of three back-to-back pairs (1,2),(3,4),(5,6), last on the third, immediately followed by a single pair (-2,7) with last. Expect f=44, then f=-14 on the next cycle, two consecutive valid_out pulses, and no carry-over of the accumulator.
3. Same vector as scenario 2 with 2-cycle bubbles between pairs. Expect f=44 with exactly one pulse, and f holds 44 while idle.
4. Saturation, macro defined: pairs (-8192,-8192) x2 with last (2*2^26 = 2^27). Expect f=134217727, ovf_out=1. Then pairs (-8192,8191) x3 with last. Expect f=-134217728, ovf_out=1. With the macro undefined, the first case gives f=-134217728, ovf_out=1. A following clean vector (1,1) last gives ovf_out=0.
5. Reset mid-vector: send (100,100), (100,100), then pulse reset for 1 cycle, then (2,3) last. Expect no valid_out for the aborted vector, f=6, ovf_out=0.
6. Latency sweep: MULT_STAGES=0 and 3 with a=5, b=-6, last. Expect f=-30 after 1 and 4 edges respectively. Run scenario 2 at both depths with identical results.

Source files
------------

// File: rtl/mac_pipe_pkg.sv
// rtl/mac_pipe_pkg.sv - shared widths, saturation limits and pipeline control type for mac_pipe_param
package mac_pipe_pkg;

    localparam int IN_W_DEF  = 14;
    localparam int ACC_W_DEF = 28;

    // Valid/last pair carried alongside each product through the multiplier pipeline
    typedef struct packed {
        logic valid;
        logic last;
    } pipe_ctl_t;

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/mac_sat_add.sv
// rtl/mac_sat_add.sv - combinational accumulator adder; clamps when MAC_PIPE_SAT_EN is defined, wraps otherwise
module mac_sat_add
    import mac_pipe_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0] i_x,
    input  logic signed [ACC_W-1:0] i_y,
    output logic signed [ACC_W-1:0] o_sum,
    output logic                    o_ovf
);

    logic signed [ACC_W-1:0] w_raw;

    assign w_raw = i_x + i_y;
    // Same-sign operands producing an opposite-sign result is the only overflow case
    assign o_ovf = (i_x[ACC_W-1] == i_y[ACC_W-1]) && (w_raw[ACC_W-1] != i_x[ACC_W-1]);

`ifdef MAC_PIPE_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

    always_comb begin
        o_sum = w_raw;
        if (o_ovf) begin
            o_sum = i_x[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign o_sum = w_raw;
`endif

endmodule

// File: rtl/mac_pipe_param.sv
// rtl/mac_pipe_param.sv - pipelined signed dot-product MAC; MAC_PIPE_SAT_EN selects saturating accumulation
module mac_pipe_param
    import mac_pipe_pkg::*;
#(
    parameter int IN_W        = IN_W_DEF,
    parameter int ACC_W       = ACC_W_DEF,
    parameter int MULT_STAGES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    input  logic                    valid_in,
    input  logic                    last_in,
    output logic signed [ACC_W-1:0] f,
    output logic                    valid_out,
    output logic                    ovf_out
);

    typedef struct packed {
        logic [ACC_W-1:0] prod;
        pipe_ctl_t        ctl;
    } pipe_entry_t;

    logic signed [IN_W-1:0]   r_a;
    logic signed [IN_W-1:0]   r_b;
    logic                     r_last;
    logic                     r_v0;
    logic signed [2*IN_W-1:0] w_prod;
    pipe_entry_t              w_s0;
    pipe_entry_t              w_acc_in;

    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_sticky;
    logic signed [ACC_W-1:0]  w_sum;
    logic                     w_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_last <= 1'b0;
            r_v0   <= 1'b0;
        end else begin
            r_v0 <= valid_in;
            if (valid_in) begin
                r_a    <= a;
                r_b    <= b;
                r_last <= last_in;
            end
        end
    end

    assign w_prod        = r_a * r_b;
    assign w_s0.prod     = ACC_W'(w_prod);
    assign w_s0.ctl      = '{valid: r_v0, last: r_last};

    for (genvar g = 0; g < MULT_STAGES; g++) begin : g_stage
        pipe_entry_t w_src;
        pipe_entry_t r_q;

        if (g == 0) begin : g_first
            assign w_src = w_s0;
        end else begin : g_next
            assign w_src = g_stage[g-1].r_q;
        end

        // Data and last hold across bubbles; only the valid bit shifts every cycle
        always_ff @(posedge clk) begin
            if (reset) begin
                r_q <= '0;
            end else begin
                r_q.ctl.valid <= w_src.ctl.valid;
                if (w_src.ctl.valid) begin
                    r_q.prod     <= w_src.prod;
                    r_q.ctl.last <= w_src.ctl.last;
                end
            end
        end
    end

    if (MULT_STAGES == 0) begin : g_direct
        assign w_acc_in = w_s0;
    end else begin : g_piped
        assign w_acc_in = g_stage[MULT_STAGES-1].r_q;
    end

    mac_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .i_x   (r_acc),
        .i_y   ($signed(w_acc_in.prod)),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= '0;
            r_sticky  <= 1'b0;
            f         <= '0;
            valid_out <= 1'b0;
            ovf_out   <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (w_acc_in.ctl.valid) begin
                if (w_acc_in.ctl.last) begin
                    f         <= w_sum;
                    ovf_out   <= r_sticky | w_ovf;
                    valid_out <= 1'b1;
                    r_acc     <= '0;
                    r_sticky  <= 1'b0;
                end else begin
                    r_acc    <= w_sum;
                    r_sticky <= r_sticky | w_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe_param.sv
// tb/tb_mac_pipe_param.sv - scoreboard bench for mac_pipe_param at MULT_STAGES 0, 1 and 3
module tb_mac_pipe_param;

    typedef struct {
        logic signed [27:0] f;
        logic               o;
        int                 cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [13:0] a = '0;
    logic signed [13:0] b = '0;
    logic               valid_in = 1'b0;
    logic               last_in = 1'b0;

    logic signed [27:0] f0, f1, f3;
    logic               v0, v1, v3;
    logic               o0, o1, o3;

    int compared = 0;
    int mism = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic last_rst = 1'b1;
    logic signed [27:0] held [3];
    exp_t q0[$], q1[$], q3[$];

    always #5 clk = ~clk;

    mac_pipe_param #(.IN_W(14), .ACC_W(28), .MULT_STAGES(0)) u_dut0 (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .last_in(last_in),
        .f(f0), .valid_out(v0), .ovf_out(o0));
    mac_pipe_param #(.IN_W(14), .ACC_W(28), .MULT_STAGES(1)) u_dut1 (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .last_in(last_in),
        .f(f1), .valid_out(v1), .ovf_out(o1));
    mac_pipe_param #(.IN_W(14), .ACC_W(28), .MULT_STAGES(3)) u_dut3 (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .last_in(last_in),
        .f(f3), .valid_out(v3), .ovf_out(o3));

    always @(posedge clk) begin
        cyc++;
        last_rst <= reset;
    end

    task automatic chk(input int k, input logic v, input logic signed [27:0] fv, input logic ov);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (last_rst) held[k] = '0;
        if (v) begin
            case (k)
                0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
            endcase
            compared++;
            if (!have) begin
                mism++;
                $display("FAIL spurious_pulse dut%0d cyc=%0d f=%0d, required no pulse", k, cyc, fv);
            end else begin
                if (fv !== e.f || ov !== e.o || cyc != e.cyc) begin
                    mism++;
                    $display("FAIL result dut%0d got f=%0d ovf=%0b cyc=%0d, required f=%0d ovf=%0b cyc=%0d",
                             k, fv, ov, cyc, e.f, e.o, e.cyc);
                end
                held[k] = e.f;
            end
        end else begin
            compared++;
            if (fv !== held[k]) begin
                mism++;
                $display("FAIL hold dut%0d cyc=%0d f=%0d, required %0d", k, cyc, fv, held[k]);
            end
            case (k)
                0: if (q0.size() > 0 && cyc > q0[0].cyc) begin e = q0.pop_front(); have = 1'b1; end
                1: if (q1.size() > 0 && cyc > q1[0].cyc) begin e = q1.pop_front(); have = 1'b1; end
                default: if (q3.size() > 0 && cyc > q3[0].cyc) begin e = q3.pop_front(); have = 1'b1; end
            endcase
            if (have) begin
                compared++;
                mism++;
                $display("FAIL missing_pulse dut%0d got none by cyc=%0d, required f=%0d at cyc=%0d", k, cyc, e.f, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk(0, v0, f0, o0);
            chk(1, v1, f1, o1);
            chk(2, v3, f3, o3);
        end
    end

    task automatic send(input int av, input int bv, input bit lst, input int ef, input bit eo);
        exp_t e;
        @(posedge clk);
        #1;
        a        = 14'(av);
        b        = 14'(bv);
        valid_in = 1'b1;
        last_in  = lst;
        if (lst) begin
            e.f = 28'(ef);
            e.o = eo;
            e.cyc = cyc + 2; q0.push_back(e);
            e.cyc = cyc + 3; q1.push_back(e);
            e.cyc = cyc + 5; q3.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            last_in  = 1'b0;
        end
    endtask

    task automatic chk_reset_state(input string nm, input logic signed [27:0] fv, input logic v, input logic ov);
        compared++;
        if (fv !== '0 || v !== 1'b0 || ov !== 1'b0) begin
            mism++;
            $display("FAIL %s got f=%0d valid=%0b ovf=%0b, required 0/0/0", nm, fv, v, ov);
        end
    endtask

    initial begin
        held[0] = '0;
        held[1] = '0;
        held[2] = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset_state("reset_dut0", f0, v0, o0);
        chk_reset_state("reset_dut1", f1, v1, o1);
        chk_reset_state("reset_dut3", f3, v3, o3);
        mon_en = 1'b1;

        send(3, 4, 1, 12, 0);
        idle(6);

        send(1, 2, 0, 0, 0);
        send(3, 4, 0, 0, 0);
        send(5, 6, 1, 44, 0);
        send(-2, 7, 1, -14, 0);
        idle(6);

        send(1, 2, 0, 0, 0);
        idle(2);
        send(3, 4, 0, 0, 0);
        idle(2);
        send(5, 6, 1, 44, 0);
        idle(8);

        send(-8192, -8192, 0, 0, 0);
`ifdef MAC_PIPE_SAT_EN
        send(-8192, -8192, 1, 134217727, 1);
`else
        send(-8192, -8192, 1, -134217728, 1);
`endif
        send(-8192, 8191, 0, 0, 0);
        send(-8192, 8191, 0, 0, 0);
`ifdef MAC_PIPE_SAT_EN
        send(-8192, 8191, 1, -134217728, 1);
`else
        send(-8192, 8191, 1, 67133440, 1);
`endif
        send(1, 1, 1, 1, 0);
        idle(8);

        send(100, 100, 0, 0, 0);
        send(100, 100, 0, 0, 0);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        valid_in = 1'b0;
        last_in  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(2, 3, 1, 6, 0);
        idle(8);

        send(5, -6, 1, -30, 0);
        idle(8);

        compared++;
        if (q0.size() != 0 || q1.size() != 0 || q3.size() != 0) begin
            mism++;
            $display("FAIL drain got pending %0d/%0d/%0d, required 0/0/0", q0.size(), q1.size(), q3.size());
        end
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
